muller_c_arbiter: RTL and testbench
===================================

# muller_c_arbiter

Synchronous four-phase arbiter and sequencer that shares one external Muller C-element between two requesters. Each requester asks for the element's output to be driven to a target level. The block grants access round-robin, drives both C-element inputs, waits for the synchronized output to settle, and then completes the requester's handshake with the sampled result. It sits between the user-project logic and the C-element in the muller_c project, and replaces direct `io_in` pin driving.

## Interface
Parameters:
- `SYNC_STAGES`, 2 — flops in the `c_q` synchronizer; minimum 2.
- `TIMEOUT_W`, 8 — watchdog counter width; timeout fires after 2^TIMEOUT_W−1 cycles.

Ports:
- `clock` input 1 — single clock, rising edge.
- `reset_n` input 1 — asynchronous, active-low reset.
- `req0` / `req1` input 1 — four-phase requests, synchronous to `clock`.
- `lvl0` / `lvl1` input 1 — target level; must be stable while the matching `req` is high.
- `ack0` / `ack1` output 1 — four-phase acknowledges.
- `result` output 1 — synchronized `c_q` captured at completion; valid while any `ack` is high.
- `c_a`, `c_b` output 1 — registered drives to the C-element inputs.
- `c_q` input 1 — C-element output; asynchronous, enters only through the synchronizer.
- `grant` output 2 — one-hot owner; 00 when idle.
- `timeout_err` output 1 — sticky watchdog flag.

## Operation
- FSM states: IDLE, DRIVE, WAIT_Q, ACK, RELEASE.
- IDLE:
  - On any `req` high, choose a winner and go to DRIVE.
  - If only one `req` is high, it wins.
  - If both are high, the requester other than `last` wins. `last` resets to 1, so `req0` wins the first tie.
- DRIVE:
  - `c_a` and `c_b` take the winner's `lvl`.
  - `grant` is set one-hot, `last` is updated, the watchdog clears, then go to WAIT_Q.
- WAIT_Q: when `c_q_sync == lvl`, latch `result` and go to ACK. The watchdog increments every cycle spent here.
- ACK:
  - The winner's `ack` is high.
  - When the winner's `req` goes low, go to RELEASE.
- RELEASE: `ack` drops, `grant` goes to 00, go to IDLE. A new grant can issue from the next IDLE cycle.
- `c_a` and `c_b` keep the last driven level after a transaction, so the C-element holds state. They change only in DRIVE.
- A request to the level the output already has completes normally; WAIT_Q exits on its first evaluation.
- A loser's `req` stays pending with no ack. It is served right after RELEASE.
- A request that drops before its ack is a protocol violation; behaviour is undefined and the bench checks for it.

## Timing
- Reset values: all outputs 0 (`ack0`, `ack1`, `result`, `c_a`, `c_b`, `grant`, `timeout_err`). Synchronizer flops are 0, FSM is in IDLE, `last` is 1.
- Reset asserted mid-transaction aborts immediately. `c_a` and `c_b` return to 0 asynchronously.
- Latency, `req` rise to `ack` rise, with `c_q` following `c_a`/`c_b` combinationally: IDLE(1) + DRIVE(1) + SYNC_STAGES + 1 = 5 cycles at default.
- Latency, `req` fall to `ack` fall: 2 cycles (ACK detects the fall, then RELEASE).
- Simultaneous `req` rise in the same cycle is resolved by the round-robin rule above.

## Configuration
- `MULLER_C_ARB_TIMEOUT_EN` defined:
  - If the watchdog reaches 2^TIMEOUT_W−1 in WAIT_Q, go to ACK with `result` = current `c_q_sync`.
  - `timeout_err` is set and stays set until reset.
- Not defined:
  - No counter is built, `timeout_err` is tied 0.
  - WAIT_Q waits indefinitely.

## Test plan
- Reset, then `req0`=1 with `lvl0`=1 and a model C-element: `c_a`=`c_b`=1, `ack0` rises exactly 5 cycles after `req0`, `result`=1, `grant`=01.
- `req0` and `req1` rise in the same cycle with `lvl0`=1, `lvl1`=0: `req0` served first; `req1` is granted in the IDLE cycle after RELEASE and ends with `c_a`=`c_b`=0, `result`=0.
- Back-to-back `req1` transactions while `req0` is held high: grants alternate 10, 01, 10.
- Request for a level equal to the current output (`c_q`=1, `lvl0`=1): `ack0` still rises after 5 cycles, and `c_a`/`c_b` are unchanged.
- With `MULLER_C_ARB_TIMEOUT_EN` defined and `c_q` stuck at 0, `lvl0`=1: `ack0` rises after 255 WAIT_Q cycles, `timeout_err`=1 and stays 1 across later transactions until `reset_n` is pulsed.
- Assert `reset_n`=0 during WAIT_Q: all outputs go to 0 without waiting for a clock edge; the next request after release behaves as from cold reset, so the first tie goes to `req0`.

Source files
------------

// File: rtl/muller_c_arbiter.sv
// Round-robin four-phase sequencer sharing one external Muller C-element between two requesters.
// Optional watchdog on the settle wait: define MULLER_C_ARB_TIMEOUT_EN.
module muller_c_arbiter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT_W   = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       req0,
   input  logic       req1,
   input  logic       lvl0,
   input  logic       lvl1,
   output logic       ack0,
   output logic       ack1,
   output logic       result,
   output logic       c_a,
   output logic       c_b,
   input  logic       c_q,
   output logic [1:0] grant,
   output logic       timeout_err
);

   localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_WAIT_Q,
      ST_ACK,
      ST_RELEASE
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                 w_c_q_sync;
   logic                 r_win, w_win_nxt;
   logic                 r_last, w_last_nxt;
   logic                 r_drv, w_drv_nxt;
   logic                 r_result, w_result_nxt;
   logic [1:0]           r_ack, w_ack_nxt;
   logic [1:0]           r_grant, w_grant_nxt;
   logic [SETTLE_W-1:0]  r_settle, w_settle_nxt;
   logic                 w_settled;
   logic                 w_win_req;
   logic                 w_win_lvl;
   logic [1:0]           w_win_onehot;
`ifdef MULLER_C_ARB_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] r_wd, w_wd_nxt, w_wd_inc;
   logic                 r_tmo, w_tmo_nxt;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_sync <= '0;
      else          r_sync <= {r_sync[SYNC_STAGES-2:0], c_q};
   end

   assign w_c_q_sync   = r_sync[SYNC_STAGES-1];
   assign w_win_req    = r_win ? req1 : req0;
   assign w_win_lvl    = r_win ? lvl1 : lvl0;
   assign w_win_onehot = r_win ? 2'b10 : 2'b01;
   // Compare only once the synchronizer holds a sample taken after the new drive,
   // so latency is fixed even when the output already sits at the target level.
   assign w_settled    = (r_settle == SETTLE_W'(SYNC_STAGES));
`ifdef MULLER_C_ARB_TIMEOUT_EN
   assign w_wd_inc     = r_wd + 1'b1;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_win_nxt    = r_win;
      w_last_nxt   = r_last;
      w_drv_nxt    = r_drv;
      w_result_nxt = r_result;
      w_ack_nxt    = r_ack;
      w_grant_nxt  = r_grant;
      w_settle_nxt = r_settle;
`ifdef MULLER_C_ARB_TIMEOUT_EN
      w_wd_nxt     = r_wd;
      w_tmo_nxt    = r_tmo;
`endif
      case (r_state)
         ST_IDLE: begin
            if (req0 || req1) begin
               w_win_nxt   = (req0 && req1) ? ~r_last : req1;
               w_state_nxt = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            w_drv_nxt    = w_win_lvl;
            w_grant_nxt  = w_win_onehot;
            w_last_nxt   = r_win;
            w_settle_nxt = '0;
`ifdef MULLER_C_ARB_TIMEOUT_EN
            w_wd_nxt     = '0;
`endif
            w_state_nxt  = ST_WAIT_Q;
         end
         ST_WAIT_Q: begin
            if (!w_settled) w_settle_nxt = r_settle + 1'b1;
`ifdef MULLER_C_ARB_TIMEOUT_EN
            w_wd_nxt = w_wd_inc;
`endif
            if (w_settled && (w_c_q_sync == r_drv)) begin
               w_result_nxt = w_c_q_sync;
               w_ack_nxt    = w_win_onehot;
               w_state_nxt  = ST_ACK;
            end
`ifdef MULLER_C_ARB_TIMEOUT_EN
            else if (w_wd_inc == '1) begin
               w_result_nxt = w_c_q_sync;
               w_ack_nxt    = w_win_onehot;
               w_tmo_nxt    = 1'b1;
               w_state_nxt  = ST_ACK;
            end
`endif
         end
         ST_ACK: begin
            if (!w_win_req) w_state_nxt = ST_RELEASE;
         end
         ST_RELEASE: begin
            w_ack_nxt   = '0;
            w_grant_nxt = '0;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_win    <= 1'b0;
         r_last   <= 1'b1;
         r_drv    <= 1'b0;
         r_result <= 1'b0;
         r_ack    <= '0;
         r_grant  <= '0;
         r_settle <= '0;
`ifdef MULLER_C_ARB_TIMEOUT_EN
         r_wd     <= '0;
         r_tmo    <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_win    <= w_win_nxt;
         r_last   <= w_last_nxt;
         r_drv    <= w_drv_nxt;
         r_result <= w_result_nxt;
         r_ack    <= w_ack_nxt;
         r_grant  <= w_grant_nxt;
         r_settle <= w_settle_nxt;
`ifdef MULLER_C_ARB_TIMEOUT_EN
         r_wd     <= w_wd_nxt;
         r_tmo    <= w_tmo_nxt;
`endif
      end
   end

   assign ack0   = r_ack[0];
   assign ack1   = r_ack[1];
   assign result = r_result;
   assign c_a    = r_drv;
   assign c_b    = r_drv;
   assign grant  = r_grant;
`ifdef MULLER_C_ARB_TIMEOUT_EN
   assign timeout_err = r_tmo;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_muller_c_arbiter.sv
// Bench for muller_c_arbiter: C-element environment model plus transaction-level
// round-robin reference; directed scenarios followed by randomized request patterns.
module tb_muller_c_arbiter;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic       lvl0 = 1'b0, lvl1 = 1'b0;
   logic       c_q  = 1'b0;
   logic       ack0, ack1, result, c_a, c_b, timeout_err;
   logic [1:0] grant;

   int total = 0;
   int bad   = 0;

   // reference state: who was served last, level the element holds, sticky error
   bit m_last = 1'b1;
   bit m_c    = 1'b0;
   bit m_tmo  = 1'b0;
   bit stuck_en  = 1'b0;
   bit stuck_val = 1'b0;

   muller_c_arbiter #(.SYNC_STAGES(2), .TIMEOUT_W(8)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req0        (req0),
      .req1        (req1),
      .lvl0        (lvl0),
      .lvl1        (lvl1),
      .ack0        (ack0),
      .ack1        (ack1),
      .result      (result),
      .c_a         (c_a),
      .c_b         (c_b),
      .c_q         (c_q),
      .grant       (grant),
      .timeout_err (timeout_err)
   );

   always #5 clock = ~clock;

   // C-element: output follows when inputs agree, holds otherwise
   always @(c_a or c_b or stuck_en or stuck_val) begin
      if (stuck_en)          c_q = stuck_val;
      else if (c_a === c_b)  c_q = c_a;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack"},    {ack1, ack0}, 2'b00);
      chk({tag, "_grant"},  grant, 2'b00);
      chk({tag, "_result"}, {1'b0, result}, 2'b00);
      chk({tag, "_cab"},    {c_b, c_a}, 2'b00);
      chk({tag, "_tmo"},    {1'b0, timeout_err}, 2'b00);
   endtask

   // Serve whichever request the round-robin rule picks; lat = cycles from request
   // visible in IDLE to ack high.
   task automatic serve(input int lat, output bit win);
      bit         w, lv, er;
      logic [1:0] g;
      w  = (req0 && req1) ? !m_last : req1;
      lv = w ? lvl1 : lvl0;
      g  = w ? 2'b10 : 2'b01;
      er = stuck_en ? stuck_val : lv;
      for (int k = 1; k <= lat; k++) begin
         tick();
         chk("c_a_track", {1'b0, c_a}, {1'b0, (k >= 2) ? lv : m_c});
         if (k < lat) chk("early_ack", {ack1, ack0}, 2'b00);
      end
      chk("ack",    {ack1, ack0}, g);
      chk("grant",  grant, g);
      chk("result", {1'b0, result}, {1'b0, er});
      chk("c_b",    {1'b0, c_b}, {1'b0, lv});
      chk("tmo",    {1'b0, timeout_err}, {1'b0, m_tmo});
      m_last = w;
      m_c    = lv;
      win    = w;
   endtask

   task automatic release_win(input bit w);
      if (w) req1 = 1'b0;
      else   req0 = 1'b0;
      tick();
      chk("ack_hold", {ack1, ack0}, w ? 2'b10 : 2'b01);
      tick();
      chk("ack_fall",   {ack1, ack0}, 2'b00);
      chk("grant_idle", grant, 2'b00);
   endtask

   initial begin
      bit w;
      int mask;

      // cold reset
      tick();
      chk_all_zero("reset");
      tick();
      reset_n = 1'b1;
      tick();

      // single request to level 1
      lvl0 = 1'b1; req0 = 1'b1;
      serve(5, w);
      release_win(w);

      // asynchronous reset while waiting for the output
      lvl1 = 1'b1; req1 = 1'b1;
      repeat (3) tick();
      chk("pre_rst_grant", grant, 2'b10);
      chk("pre_rst_cab",   {c_b, c_a}, 2'b11);
      reset_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      req1 = 1'b0;
      tick();
      reset_n = 1'b1;
      m_last = 1'b1; m_c = 1'b0; m_tmo = 1'b0;
      tick();

      // simultaneous requests after reset: req0 first, then req1 drives 0
      lvl0 = 1'b1; lvl1 = 1'b0; req0 = 1'b1; req1 = 1'b1;
      serve(5, w);
      chk("tie_first_grant", grant, 2'b01);
      release_win(w);
      serve(5, w);
      chk("tie_second_cab", {c_b, c_a}, 2'b00);
      release_win(w);

      // alternating owners with the other side re-requesting during ACK
      lvl1 = 1'b1; req1 = 1'b1;
      serve(5, w);
      lvl0 = 1'b0; req0 = 1'b1;
      release_win(w);
      serve(5, w);
      lvl1 = 1'b0; req1 = 1'b1;
      release_win(w);
      serve(5, w);
      release_win(w);

      // request for the level the element already holds
      lvl0 = m_c; req0 = 1'b1;
      serve(5, w);
      release_win(w);

      // randomized request patterns
      repeat (24) begin
         mask = $urandom_range(1, 3);
         lvl0 = 1'($urandom); lvl1 = 1'($urandom);
         req0 = mask[0]; req1 = mask[1];
         serve(5, w);
         if ($urandom_range(0, 1) == 1) begin
            if (w) begin if (!req0) begin lvl0 = 1'($urandom); req0 = 1'b1; end end
            else   begin if (!req1) begin lvl1 = 1'($urandom); req1 = 1'b1; end end
         end
         release_win(w);
         for (int n = 0; n < 2; n++) begin
            if (req0 || req1) begin
               serve(5, w);
               release_win(w);
            end
         end
      end

`ifdef MULLER_C_ARB_TIMEOUT_EN
      // stuck output: watchdog completes the transaction and latches the error
      stuck_en = 1'b1; stuck_val = 1'b0;
      lvl0 = 1'b1; req0 = 1'b1;
      m_tmo = 1'b1;
      serve(257, w);
      release_win(w);
      stuck_en = 1'b0;
      #1;
      lvl1 = 1'b1; req1 = 1'b1;
      serve(5, w);
      release_win(w);
      reset_n = 1'b0;
      #1;
      chk("tmo_cleared", {1'b0, timeout_err}, 2'b00);
      tick();
      reset_n = 1'b1;
      m_last = 1'b1; m_c = 1'b0; m_tmo = 1'b0;
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
